// File: rtl/song_sequencer.sv
// Song playback controller: walks the note memory, holds each note for its beat count
// and drives the tone generator. A zero-duration word marks the end of the song.
module song_sequencer #(
    parameter int SONG_LEN    = 12,
    parameter int ENC_LEN     = 12,
    parameter int ADDR_W      = 6,
    parameter int BEAT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                play,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [ENC_LEN-1:0]  mem_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [ENC_LEN-5:0]  tone,
    output logic                tone_valid,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [ENC_LEN-5:0]  tone_nxt;
    logic [3:0]          beats_left, beats_nxt;
    logic [CNT_W-1:0]    beat_cnt, cnt_nxt;
    logic                done_pulse, done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_addr   <= '0;
            tone       <= '0;
            beats_left <= '0;
            beat_cnt   <= '0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_addr   <= addr_nxt;
            tone       <= tone_nxt;
            beats_left <= beats_nxt;
            beat_cnt   <= cnt_nxt;
            done_pulse <= done_nxt;
        end
    end

    // Stop overrides everything; done is only raised on the transition into DONE
    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_addr;
        tone_nxt  = tone;
        beats_nxt = beats_left;
        cnt_nxt   = beat_cnt;
        done_nxt  = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
            beats_nxt = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (play) begin
                        state_nxt = FETCH;
                        addr_nxt  = '0;
                    end
                end
                FETCH: begin
                    tone_nxt  = mem_data[ENC_LEN-1:4];
                    beats_nxt = mem_data[3:0];
                    cnt_nxt   = '0;
                    if (mem_data[3:0] == 4'd0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (beat_cnt == BEAT_LAST) begin
                        cnt_nxt   = '0;
                        beats_nxt = beats_left - 4'd1;
                        if (beats_left == 4'd1) begin
                            if (mem_addr < ADDR_LAST) begin
                                addr_nxt  = mem_addr + 1'b1;
                                state_nxt = FETCH;
                            end else if (loop_en) begin
                                addr_nxt  = '0;
                                state_nxt = FETCH;
                            end else begin
                                state_nxt = DONE;
                                done_nxt  = 1'b1;
                            end
                        end
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (play) begin
                        state_nxt = FETCH;
                        addr_nxt  = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign tone_valid = (state == HOLD);
    assign busy       = (state == FETCH) || (state == HOLD);
    assign done       = done_pulse;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboarded bench for song_sequencer: a song-level model predicts the sequence of
// notes (tone, length, gap) and done pulses; a monitor rebuilds the same events from the pins.
module tb_song_sequencer;

    localparam int SONG_LEN    = 4;
    localparam int ENC_LEN     = 12;
    localparam int ADDR_W      = 6;
    localparam int BEAT_CYCLES = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               play = 1'b0;
    logic               stop = 1'b0;
    logic               loop_en = 1'b0;
    logic [ENC_LEN-1:0] mem_data;
    logic [ADDR_W-1:0]  mem_addr;
    logic [ENC_LEN-5:0] tone;
    logic               tone_valid;
    logic               busy;
    logic               done;

    logic [ENC_LEN-1:0] song [SONG_LEN];

    typedef struct {
        bit   isDone;
        int   toneVal;
        int   len;
        int   gap;
        int   stable;
        int   addr;
    } ev_t;

    ev_t expQ[$];
    int  nChecks = 0;
    int  nPassed = 0;

    song_sequencer #(
        .SONG_LEN(SONG_LEN), .ENC_LEN(ENC_LEN), .ADDR_W(ADDR_W), .BEAT_CYCLES(BEAT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .loop_en(loop_en),
        .mem_data(mem_data), .mem_addr(mem_addr), .tone(tone),
        .tone_valid(tone_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign mem_data = song[mem_addr[1:0]];

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) nPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushNote(input int t, input int len);
        ev_t e;
        e.isDone = 1'b0; e.toneVal = t; e.len = len; e.gap = 1; e.stable = 1; e.addr = 0;
        expQ.push_back(e);
    endtask

    task automatic pushDone(input int addr);
        ev_t e;
        e.isDone = 1'b1; e.toneVal = 0; e.len = 0; e.gap = 0; e.stable = 1; e.addr = addr;
        expQ.push_back(e);
    endtask

    // Song-level model: play words in order, stop at a marker, optionally play a second pass
    task automatic predictSong(input bit twoPasses);
        int passes;
        int dur;
        passes = twoPasses ? 2 : 1;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < SONG_LEN; i++) begin
                dur = int'(song[i][3:0]);
                if (dur == 0) begin
                    pushDone(i);
                    return;
                end
                pushNote(int'(song[i][ENC_LEN-1:4]), dur * BEAT_CYCLES);
            end
        end
        pushDone(SONG_LEN - 1);
    endtask

    task automatic scoreEvent(input ev_t got);
        ev_t exp;
        if (expQ.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL unexpected_event: got done=%0d tone=%0d len=%0d addr=%0d, expected no event",
                     got.isDone, got.toneVal, got.len, got.addr);
            return;
        end
        exp = expQ.pop_front();
        checkOutput("event_is_done", int'(got.isDone), int'(exp.isDone));
        if (got.isDone == exp.isDone) begin
            if (got.isDone) begin
                checkOutput("done_addr", got.addr, exp.addr);
            end else begin
                checkOutput("note_tone", got.toneVal, exp.toneVal);
                checkOutput("note_len", got.len, exp.len);
                checkOutput("note_gap", got.gap, exp.gap);
                checkOutput("note_stable", got.stable, exp.stable);
            end
        end
    endtask

    // Monitor: turns pin activity into note/done events; aborted notes are discarded
    int   gapCnt = 0;
    bit   inRun = 1'b0;
    ev_t  run;
    always @(negedge clk) begin
        ev_t d;
        if (!rst_n || stop) begin
            inRun  = 1'b0;
            gapCnt = 0;
        end else begin
            if (tone_valid) begin
                if (!inRun) begin
                    inRun       = 1'b1;
                    run.isDone  = 1'b0;
                    run.toneVal = int'(tone);
                    run.len     = 0;
                    run.gap     = gapCnt;
                    run.stable  = 1;
                    run.addr    = int'(mem_addr);
                end
                run.len++;
                if (int'(tone) != run.toneVal) run.stable = 0;
            end else begin
                if (inRun) begin
                    scoreEvent(run);
                    inRun  = 1'b0;
                    gapCnt = 0;
                end
                if (busy) gapCnt++;
                else gapCnt = 0;
            end
            if (done) begin
                d.isDone = 1'b1; d.toneVal = 0; d.len = 0; d.gap = 0; d.stable = 1;
                d.addr = int'(mem_addr);
                scoreEvent(d);
            end
        end
    end

    task automatic waitDrain(input int clearAt, input bit randomPlay, input int budget);
        int cyc;
        cyc = 0;
        while (expQ.size() != 0 && cyc < budget) begin
            if (clearAt >= 0 && expQ.size() <= clearAt) loop_en = 1'b0;
            play = randomPlay && busy && ($urandom_range(0, 5) == 0);
            tick();
            cyc++;
        end
        play = 1'b0;
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout_pending", expQ.size(), 0);
            expQ.delete();
        end
        repeat (3) tick();
    endtask

    task automatic applyStimulus(input bit loopMode, input bit randomPlay);
        bit hasMarker;
        int clearAt;
        hasMarker = 1'b0;
        for (int i = 0; i < SONG_LEN; i++)
            if (song[i][3:0] == 4'd0) hasMarker = 1'b1;
        loop_en = loopMode;
        clearAt = (loopMode && !hasMarker) ? SONG_LEN + 1 : -1;
        predictSong(loopMode && !hasMarker);
        play = 1'b1;
        tick();
        play = 1'b0;
        waitDrain(clearAt, randomPlay, 500);
    endtask

    task automatic waitTone(input int t, input int extra);
        int cyc;
        cyc = 0;
        while (!(tone_valid && int'(tone) == t) && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) checkOutput("wait_tone_timeout", cyc, 0);
        repeat (extra) tick();
    endtask

    task automatic loadDefault();
        song[0] = {8'h11, 4'd1};
        song[1] = {8'h22, 4'd2};
        song[2] = {8'h33, 4'd1};
        song[3] = {8'h44, 4'd1};
    endtask

    initial begin
        loadDefault();
        #12;
        checkOutput("reset_tone_valid", int'(tone_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_addr", int'(mem_addr), 0);
        checkOutput("reset_tone", int'(tone), 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        applyStimulus(1'b0, 1'b0);
        checkOutput("done_addr_held", int'(mem_addr), SONG_LEN - 1);
        checkOutput("done_cleared", int'(done), 0);

        applyStimulus(1'b1, 1'b0);

        song[2] = {8'h33, 4'd0};
        applyStimulus(1'b0, 1'b0);
        checkOutput("marker_addr_held", int'(mem_addr), 2);
        loadDefault();

        applyStimulus(1'b0, 1'b1);

        $display("[TB] stop during second note");
        predictSong(1'b0);
        play = 1'b1;
        tick();
        play = 1'b0;
        waitTone(8'h22, BEAT_CYCLES + 1);
        stop = 1'b1;
        expQ.delete();
        tick();
        stop = 1'b0;
        checkOutput("stop_tone_valid", int'(tone_valid), 0);
        checkOutput("stop_addr", int'(mem_addr), 0);
        checkOutput("stop_busy", int'(busy), 0);
        checkOutput("stop_done", int'(done), 0);
        repeat (2) tick();
        checkOutput("stop_stays_idle", int'(busy), 0);

        play = 1'b1;
        stop = 1'b1;
        tick();
        play = 1'b0;
        stop = 1'b0;
        checkOutput("play_stop_busy", int'(busy), 0);
        tick();
        checkOutput("play_stop_still_idle", int'(busy), 0);

        $display("[TB] reset pulse mid-note");
        predictSong(1'b0);
        play = 1'b1;
        tick();
        play = 1'b0;
        waitTone(8'h33, 1);
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("async_rst_tone_valid", int'(tone_valid), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_addr", int'(mem_addr), 0);
        checkOutput("async_rst_tone", int'(tone), 0);
        checkOutput("async_rst_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < SONG_LEN; i++)
                song[i] = {8'($urandom_range(0, 255)), 4'($urandom_range(1, 3))};
            if ($urandom_range(0, 3) == 0) song[$urandom_range(0, SONG_LEN - 1)][3:0] = 4'd0;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
